// File: rtl/bcd_time_loader.sv
// Purpose : converts a packed BCD time value (MS digit first) into a binary tick count.
// Latency : DIGITS edges after the Start-sampling edge for valid input, 1 edge for invalid.
// Backpr. : Start is only sampled while idle; requests during Busy are dropped, not queued.
//
// Ports:
//   Clk      rising-edge clock
//   Rst      asynchronous active-low reset
//   Start    conversion request, sampled only in IDLE
//   Dig_In   packed BCD, [4*DIGITS-1 -: 4] is the most significant digit
//   Bin_Out  last successfully converted value, held between conversions
//   Busy     high from the accepting edge until the completion edge
//   Done     one-cycle completion pulse (success or error)
//   Err      raised with Done when a captured digit exceeds 9, held until the next accept
module bcd_time_loader #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 11
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   Dig_In,
  output logic [OUT_W-1:0]      Bin_Out,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_CONV  = 2'd2;

  localparam int DIG_W  = 4 * DIGITS;
  localparam int WIDE_W = OUT_W + 4;
  // Index of the next digit to fold in; a single-digit build still needs a 1-bit register.
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'((DIGITS > 1) ? (DIGITS - 2) : 0);

  logic [1:0]        state_q, state_d;
  logic [DIG_W-1:0]  dig_q,   dig_d;
  logic [OUT_W-1:0]  acc_q,   acc_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [OUT_W-1:0]  bin_q,   bin_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  logic              any_bad;
  logic [3:0]        ms_digit;
  logic [3:0]        cur_digit;
  logic [WIDE_W-1:0] acc_wide;
  logic [OUT_W-1:0]  acc_next;

  // Validity is judged on the captured copy, so Dig_In may change freely after acceptance.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] > 4'd9) begin
        any_bad = 1'b1;
      end
    end
  end

  assign ms_digit  = dig_q[DIG_W-1 -: 4];
  assign cur_digit = dig_q[{idx_q, 2'b00} +: 4];

  // acc*10 + digit as shift-and-add, widened so the intermediate cannot wrap; the
  // result always fits OUT_W when 2^OUT_W exceeds the largest DIGITS-digit value.
  assign acc_wide = WIDE_W'(acc_q);
  assign acc_next = OUT_W'((acc_wide << 3) + (acc_wide << 1) + WIDE_W'(cur_digit));

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          dig_d   = Dig_In;
          acc_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (any_bad) begin
          // Bin_Out keeps the previous good value; only the error is reported.
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (DIGITS == 1) begin
          bin_d   = OUT_W'(ms_digit);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          acc_d   = OUT_W'(ms_digit);
          idx_d   = IDX_START;
          state_d = ST_CONV;
        end
      end

      ST_CONV: begin
        acc_d = acc_next;
        if (idx_q == '0) begin
          // LS digit folded in: publish the finished value only now.
          bin_d   = acc_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      dig_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Bin_Out = bin_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Purpose : self-checking bench for bcd_time_loader (3 digits, 11-bit result).
// Latency : expects Done 3 edges after acceptance for valid input, 1 edge for invalid.
// Backpr. : exercises Start during Busy (dropped) and Start during the Done cycle (accepted).
module tb_bcd_time_loader;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [11:0] Dig_In;
  logic [10:0] Bin_Out;
  logic        Busy;
  logic        Done;
  logic        Err;

  typedef struct {
    logic [10:0] bin;
    logic        err;
  } exp_t;

  typedef struct {
    logic [11:0] dig;
    logic [10:0] bin;
    logic        err;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  bcd_time_loader #(.DIGITS(3), .OUT_W(11)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Dig_In  (Dig_In),
    .Bin_Out (Bin_Out),
    .Busy    (Busy),
    .Done    (Done),
    .Err     (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Rst === 1'b1 && Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 with bin=%0d, expected no Done", Bin_Out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_bin", 32'(Bin_Out), 32'(mon_e.bin));
        chk("sb_err", 32'(Err), 32'(mon_e.err));
      end
    end
  end

  // Counts falling edges until Done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int lat);
    lat = 0;
    while (Done !== 1'b1 && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic run_conv(input logic [11:0] d, input logic [10:0] eb, input logic ee,
                          input string name);
    int   lat;
    exp_t e;
    @(negedge Clk);
    Start  = 1'b1;
    Dig_In = d;
    e.bin  = eb;
    e.err  = ee;
    sb_q.push_back(e);
    @(negedge Clk);
    // Past the accepting edge: scramble the inputs, they must not matter any more.
    Start  = 1'b0;
    Dig_In = ~d;
    chk({name, "_busy"}, 32'(Busy), 32'd1);
    chk({name, "_err_clr"}, 32'(Err), 32'd0);
    wait_done(lat);
    if (Done !== 1'b1) begin
      chk({name, "_timeout"}, 32'(Done), 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      chk({name, "_lat"}, 32'(lat), ee ? 32'd1 : 32'd3);
      chk({name, "_busy_end"}, 32'(Busy), 32'd0);
    end
    @(negedge Clk);
    chk({name, "_done_fall"}, 32'(Done), 32'd0);
    chk({name, "_bin_hold"}, 32'(Bin_Out), 32'(eb));
    chk({name, "_err_hold"}, 32'(Err), 32'(ee));
  endtask

  initial begin
    vec_t vecs[9];
    int   lat;
    exp_t e;

    // Error vectors expect Bin_Out to keep the previous good result.
    vecs[0] = '{dig: 12'h128, bin: 11'd128, err: 1'b0};
    vecs[1] = '{dig: 12'h999, bin: 11'd999, err: 1'b0};
    vecs[2] = '{dig: 12'h1A5, bin: 11'd999, err: 1'b1};
    vecs[3] = '{dig: 12'h000, bin: 11'd0,   err: 1'b0};
    vecs[4] = '{dig: 12'h305, bin: 11'd305, err: 1'b0};
    vecs[5] = '{dig: 12'hF00, bin: 11'd305, err: 1'b1};
    vecs[6] = '{dig: 12'h00A, bin: 11'd305, err: 1'b1};
    vecs[7] = '{dig: 12'h059, bin: 11'd59,  err: 1'b0};
    vecs[8] = '{dig: 12'h090, bin: 11'd90,  err: 1'b0};

    Rst    = 1'b0;
    Start  = 1'b0;
    Dig_In = 12'h000;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_bin",  32'(Bin_Out), 32'd0);
    chk("rst_busy", 32'(Busy),    32'd0);
    chk("rst_done", 32'(Done),    32'd0);
    chk("rst_err",  32'(Err),     32'd0);

    foreach (vecs[i]) begin
      run_conv(vecs[i].dig, vecs[i].bin, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Second Start one edge into a conversion must be dropped.
    @(negedge Clk);
    Start  = 1'b1;
    Dig_In = 12'h050;
    e.bin  = 11'd50;
    e.err  = 1'b0;
    sb_q.push_back(e);
    @(negedge Clk);
    Dig_In = 12'h777;
    @(negedge Clk);
    Start = 1'b0;
    lat   = 1;
    while (Done !== 1'b1 && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd3);
    @(negedge Clk);
    chk("ign_bin",  32'(Bin_Out), 32'd50);
    chk("ign_busy", 32'(Busy),    32'd0);
    @(negedge Clk);
    chk("ign_no_restart", 32'(Busy), 32'd0);

    // Start held high: each Done cycle's edge immediately accepts the next request.
    @(negedge Clk);
    Start  = 1'b1;
    Dig_In = 12'h007;
    e.bin  = 11'd7;
    e.err  = 1'b0;
    sb_q.push_back(e);
    sb_q.push_back(e);
    wait_done(lat);
    // Counted from before the accepting edge: accept + 3 conversion edges.
    chk("b2b_lat1", 32'(lat), 32'd4);
    @(negedge Clk);
    chk("b2b_done_fall", 32'(Done), 32'd0);
    chk("b2b_busy_rise", 32'(Busy), 32'd1);
    wait_done(lat);
    chk("b2b_lat2", 32'(lat), 32'd3);
    @(negedge Clk);
    chk("b2b_busy3", 32'(Busy), 32'd1);
    @(negedge Clk);
    // Third conversion is in CONV; reset lands before its first CONV edge.
    Rst   = 1'b0;
    Start = 1'b0;
    #1;
    chk("abort_bin",  32'(Bin_Out), 32'd0);
    chk("abort_busy", 32'(Busy),    32'd0);
    chk("abort_done", 32'(Done),    32'd0);
    chk("abort_err",  32'(Err),     32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk($sformatf("abort_nodone%0d", k), 32'(Done), 32'd0);
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    run_conv(12'h042, 11'd42, 1'b0, "post_rst");

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
